// File: rtl/sram_mem_stage_ctrl.sv
// sram_mem_stage_ctrl: memory-stage controller that turns one 32-bit load or
// store from the EXE/MEM register into two half-word accesses on a 16-bit
// asynchronous SRAM, holding `ready` low (freeze upstream) while busy.
// Optional macro MEM_ADDR_CHECK_EN adds `addr_err`: requests below BASE_ADDR
// or not word-aligned are rejected in one cycle with no SRAM activity.
module sram_mem_stage_ctrl #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
`ifdef MEM_ADDR_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned WORD_W = 17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_is_wr;
  logic                w_is_wr_nxt;
  logic [WORD_W-1:0]   r_word;
  logic [WORD_W-1:0]   w_word_nxt;
  logic [31:0]         r_wdata;
  logic [31:0]         w_wdata_nxt;
  logic [31:0]         r_rdata;
  logic                r_we_n;
  logic                r_oe_n;
  logic [17:0]         r_addr;
  logic                r_dq_oe;
  logic [15:0]         r_dq_out;
  logic                r_addr_err;

  logic                w_ready;
  logic                w_cap_lo;
  logic                w_cap_hi;
  logic                w_err_nxt;
  logic                w_last;
  logic                w_bus_act;
  logic                w_we_n_nxt;
  logic                w_oe_n_nxt;
  logic [17:0]         w_addr_nxt;
  logic                w_dq_oe_nxt;
  logic [15:0]         w_dq_out_nxt;
  logic [31:0]         w_offset;
  logic                w_bad_addr;
  logic                w_unused_bits;

  // Byte offset into the SRAM window; wraps below BASE_ADDR.
  assign w_offset      = address - BASE_ADDR;
  assign w_last        = (r_cnt == CNT_W'(WAIT_CYCLES - 1));
  assign w_unused_bits = ^{w_offset[31:19], w_offset[1:0]};

`ifdef MEM_ADDR_CHECK_EN
  assign w_bad_addr = (address < BASE_ADDR) || (address[1:0] != 2'b00);
`else
  assign w_bad_addr = 1'b0;
`endif

  // Next-state, request latching, capture strobes and combinational ready.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_is_wr_nxt = r_is_wr;
    w_word_nxt  = r_word;
    w_wdata_nxt = r_wdata;
    w_ready     = 1'b1;
    w_cap_lo    = 1'b0;
    w_cap_hi    = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rd_en || wr_en) begin
          w_ready     = 1'b0;
          w_is_wr_nxt = wr_en;
          w_word_nxt  = w_offset[18:2];
          w_wdata_nxt = write_data;
          w_cnt_nxt   = '0;
          if (w_bad_addr) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_LO;
          end
        end
      end
      S_LO: begin
        w_ready = 1'b0;
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_cap_lo    = !r_is_wr;
          w_state_nxt = S_HI;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_HI: begin
        w_ready = 1'b0;
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_cap_hi    = !r_is_wr;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // SRAM bus values for the coming cycle, decoded from the next state.
  always_comb begin
    w_bus_act    = (w_state_nxt == S_LO) || (w_state_nxt == S_HI);
    w_we_n_nxt   = !(w_bus_act && w_is_wr_nxt);
    w_oe_n_nxt   = !(w_bus_act && !w_is_wr_nxt);
    w_dq_oe_nxt  = w_bus_act && w_is_wr_nxt;
    w_addr_nxt   = r_addr;
    w_dq_out_nxt = w_wdata_nxt[15:0];
    if (w_bus_act) begin
      w_addr_nxt = {w_word_nxt, (w_state_nxt == S_HI)};
    end
    if (w_state_nxt == S_HI) begin
      w_dq_out_nxt = w_wdata_nxt[31:16];
    end
  end

  // State, latched request, registered bus drive and read capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_wr    <= 1'b0;
      r_word     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_we_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_addr     <= '0;
      r_dq_oe    <= 1'b0;
      r_dq_out   <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_is_wr    <= w_is_wr_nxt;
      r_word     <= w_word_nxt;
      r_wdata    <= w_wdata_nxt;
      r_we_n     <= w_we_n_nxt;
      r_oe_n     <= w_oe_n_nxt;
      r_addr     <= w_addr_nxt;
      r_dq_oe    <= w_dq_oe_nxt;
      r_dq_out   <= w_dq_out_nxt;
      r_addr_err <= w_err_nxt;
      if (w_cap_lo) begin
        r_rdata[15:0] <= SRAM_DQ;
      end
      if (w_cap_hi) begin
        r_rdata[31:16] <= SRAM_DQ;
      end
    end
  end

  assign SRAM_DQ   = r_dq_oe ? r_dq_out : 16'hzzzz;
  assign SRAM_ADDR = r_addr;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign read_data = r_rdata;
  assign ready     = w_ready;

`ifdef MEM_ADDR_CHECK_EN
  assign addr_err = r_addr_err;
`else
  logic w_unused_err;
  assign w_unused_err = r_addr_err ^ w_unused_bits;
`endif

endmodule

// File: tb/tb_sram_mem_stage_ctrl.sv
// tb_sram_mem_stage_ctrl: directed vectors against a behavioural async SRAM.
module tb_sram_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;
  logic        sram_ub_n;
  logic        sram_lb_n;
`ifdef MEM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  int errors;
  int checks;
  int both_low;
  int rd_conflict;

  logic [15:0] mem [0:63];
  logic        mem_clr;
  logic [15:0] mem_rd;

  sram_mem_stage_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_OE_N  (sram_oe_n),
    .SRAM_CE_N  (sram_ce_n),
    .SRAM_UB_N  (sram_ub_n),
    .SRAM_LB_N  (sram_lb_n)
`ifdef MEM_ADDR_CHECK_EN
    ,
    .addr_err   (addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM model: drives DQ while OE_N low and WE_N high, writes on WE_N low.
  assign mem_rd  = mem[sram_addr[5:0]];
  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem_rd : 16'hzzzz;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 64; k++) mem[k] <= 16'h0000;
    end else if (!sram_we_n) begin
      mem[sram_addr[5:0]] <= sram_dq;
    end
  end

  // Bus protocol watch: strobes never both low, read data never disturbed.
  always @(negedge clk) begin
    if (!sram_we_n && !sram_oe_n) both_low++;
    if (!sram_oe_n && sram_we_n && (sram_dq != mem_rd)) rd_conflict++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access: present request in IDLE, count ready-low cycles and strobes,
  // return read_data and addr_err as seen in the cycle ready returns high.
  task automatic do_acc(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output int we_c,
                        output int oe_c, output logic [31:0] rdat, output logic err);
    bit done;
    lat  = 0;
    we_c = 0;
    oe_c = 0;
    done = 1'b0;
    @(negedge clk);
    rd_en      = rd;
    wr_en      = wr;
    address    = a;
    write_data = d;
    #1;
    for (int i = 0; i < 64 && !done; i++) begin
      if (ready) begin
        done = 1'b1;
      end else begin
        lat++;
        if (!sram_we_n) we_c++;
        if (!sram_oe_n) oe_c++;
        @(negedge clk);
        address    = 32'h0000_0000;
        write_data = ~d;
        #1;
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL timeout: ready still %b after 64 cycles, required 1", ready);
    end
    rdat = read_data;
`ifdef MEM_ADDR_CHECK_EN
    err = addr_err;
`else
    err = 1'b0;
`endif
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          idx;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [31:0] rdata;
    int          we;
    int          oe;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int          lat;
    int          we_c;
    int          oe_c;
    logic [31:0] rdat;
    logic        err;

    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 0, 16'hBEEF, 16'hDEAD, 32'h0000_0000, 6, 0};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        0, 16'hBEEF, 16'hDEAD, 32'hDEADBEEF, 0, 6};
    vecs[2] = '{1'b0, 1'b1, 32'd1032, 32'h12345678, 4, 16'h5678, 16'h1234, 32'hDEADBEEF, 6, 0};
    vecs[3] = '{1'b1, 1'b1, 32'd1028, 32'hA5A55A5A, 2, 16'h5A5A, 16'hA5A5, 32'hDEADBEEF, 6, 0};
    vecs[4] = '{1'b1, 1'b0, 32'd1028, 32'h0,        2, 16'h5A5A, 16'hA5A5, 32'hA5A55A5A, 0, 6};

    errors      = 0;
    checks      = 0;
    both_low    = 0;
    rd_conflict = 0;
    rst         = 1'b1;
    mem_clr     = 1'b1;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    address     = 32'h0;
    write_data  = 32'h0;

    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    #1;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_rdata", read_data, 32'h0);
    chk("reset_we_n", 32'(sram_we_n), 32'd1);
    chk("reset_oe_n", 32'(sram_oe_n), 32'd1);
    chk("reset_addr", 32'(sram_addr), 32'd0);
    chk("tie_ce_ub_lb", {29'd0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single accesses, each followed by a hold check.
    for (int v = 0; v < 5; v++) begin
      do_acc(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, lat, we_c, oe_c, rdat, err);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'd7);
      chk($sformatf("v%0d_we_cycles", v), 32'(we_c), 32'(vecs[v].we));
      chk($sformatf("v%0d_oe_cycles", v), 32'(oe_c), 32'(vecs[v].oe));
      chk($sformatf("v%0d_rdata", v), rdat, vecs[v].rdata);
      chk($sformatf("v%0d_mem_lo", v), 32'(mem[vecs[v].idx]), 32'(vecs[v].lo));
      chk($sformatf("v%0d_mem_hi", v), 32'(mem[vecs[v].idx + 1]), 32'(vecs[v].hi));
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_rdata_hold", v), read_data, vecs[v].rdata);
      chk($sformatf("v%0d_idle_ready", v), 32'(ready), 32'd1);
    end

    // Back-to-back loads: next request presented in the cycle after DONE.
    do_acc(1'b1, 1'b0, 32'd1032, 32'h0, lat, we_c, oe_c, rdat, err);
    chk("b2b0_latency", 32'(lat), 32'd7);
    chk("b2b0_rdata", rdat, 32'h12345678);
    do_acc(1'b1, 1'b0, 32'd1024, 32'h0, lat, we_c, oe_c, rdat, err);
    chk("b2b1_latency", 32'(lat), 32'd7);
    chk("b2b1_rdata", rdat, 32'hDEADBEEF);

    // Reset in the first HI cycle of a store.
    @(negedge clk);
    wr_en      = 1'b1;
    address    = 32'd1040;
    write_data = 32'h11112222;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_pre_we_n", 32'(sram_we_n), 32'd0);
    chk("rst_pre_addr", 32'(sram_addr), 32'd9);
    rst   = 1'b1;
    wr_en = 1'b0;
    #1;
    chk("rst_mid_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_mid_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_rdata", read_data, 32'h0);
    chk("rst_mid_mem_lo", 32'(mem[8]), 32'h2222);
    chk("rst_mid_mem_hi", 32'(mem[9]), 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    do_acc(1'b0, 1'b1, 32'd1040, 32'h33334444, lat, we_c, oe_c, rdat, err);
    chk("post_rst_latency", 32'(lat), 32'd7);
    chk("post_rst_mem_lo", 32'(mem[8]), 32'h4444);
    chk("post_rst_mem_hi", 32'(mem[9]), 32'h3333);
    do_acc(1'b1, 1'b0, 32'd1040, 32'h0, lat, we_c, oe_c, rdat, err);
    chk("post_rst_load", rdat, 32'h33334444);

`ifdef MEM_ADDR_CHECK_EN
    // Rejected requests: one-cycle stall, error flag for the DONE cycle only.
    do_acc(1'b1, 1'b0, 32'd1000, 32'h0, lat, we_c, oe_c, rdat, err);
    chk("err_ld_latency", 32'(lat), 32'd1);
    chk("err_ld_flag", 32'(err), 32'd1);
    chk("err_ld_strobes", 32'(we_c + oe_c), 32'd0);
    chk("err_ld_rdata", rdat, 32'h33334444);
    @(negedge clk);
    #1;
    chk("err_ld_clear", 32'(addr_err), 32'd0);
    do_acc(1'b0, 1'b1, 32'd1026, 32'hFFFF_FFFF, lat, we_c, oe_c, rdat, err);
    chk("err_st_latency", 32'(lat), 32'd1);
    chk("err_st_flag", 32'(err), 32'd1);
    chk("err_st_strobes", 32'(we_c + oe_c), 32'd0);
    chk("err_st_mem", 32'(mem[0]), 32'hBEEF);
`else
    // Wrapped offset below the base and ignored low address bits.
    do_acc(1'b0, 1'b1, 32'd1020, 32'h0BADF00D, lat, we_c, oe_c, rdat, err);
    chk("wrap_latency", 32'(lat), 32'd7);
    chk("wrap_mem_lo", 32'(mem[62]), 32'hF00D);
    chk("wrap_mem_hi", 32'(mem[63]), 32'h0BAD);
    do_acc(1'b1, 1'b0, 32'd1031, 32'h0, lat, we_c, oe_c, rdat, err);
    chk("unaligned_load", rdat, 32'hA5A55A5A);
`endif

    chk("strobes_both_low", 32'(both_low), 32'd0);
    chk("read_bus_conflict", 32'(rd_conflict), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_mem_stage_ctrl.md
Name: sram_mem_stage_ctrl

Overview:
- Memory-stage controller directly downstream of the EXE/MEM pipeline register.
- Consumes the latched ALU result (address), the Rm value (store data) and the mem_read/mem_write strobes, and performs a 32-bit load/store on a 16-bit external asynchronous SRAM as two half-word accesses.
- Drives `ready` low while busy; the hazard/freeze logic uses it to stall every upstream pipeline register.

Parameters:
- WAIT_CYCLES, 3, clock cycles each half-word access is held on the SRAM bus (>=1).
- BASE_ADDR, 1024, CPU byte address mapped to SRAM half-word 0.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- rd_en  input  1  load request (mem_read from EXE/MEM register)
- wr_en  input  1  store request (mem_write from EXE/MEM register)
- address  input  32  CPU byte address (ALU result)
- write_data  input  32  store data (val_Rm)
- read_data  output  32  load result
- ready  output  1  1 = stage may advance; 0 = freeze upstream
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  output  18  SRAM half-word address
- SRAM_WE_N  output  1  write enable, active-low
- SRAM_OE_N  output  1  output enable, active-low
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  tied 0 (always enabled, both bytes)

Behaviour:
- Reset (async): state=IDLE, wait counter=0, read_data=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0, SRAM_DQ high-Z. ready=1, since no request can be present in IDLE during reset.
- Address map: offset = address - BASE_ADDR (32-bit, wraps). SRAM_ADDR = {offset[18:2], h}, with h=0 for the low half and h=1 for the high half. address[1:0] is ignored.
- FSM states are IDLE, LO, HI, DONE.
- IDLE:
  - No request: ready=1.
  - rd_en|wr_en: ready=0 combinationally. Latch op, offset and write_data; go to LO with counter=0.
  - If rd_en and wr_en are both 1, the write wins.
- LO: ready=0, SRAM_ADDR low half.
  - Write: DQ=wdata[15:0], WE_N=0.
  - Read: DQ=Z, OE_N=0.
  - Counter increments each cycle. At counter==WAIT_CYCLES-1, a read captures DQ into read_data[15:0]; then go to HI with counter=0.
- HI: same as LO for the high half.
  - Write drives wdata[31:16].
  - Read captures read_data[31:16] on the last cycle.
  - Then go to DONE.
- DONE: ready=1 for exactly one cycle. WE_N=1, OE_N=1, DQ=Z. read_data holds the complete word. Next state is IDLE unconditionally.
- Latency: ready is low for 1+2*WAIT_CYCLES cycles from the cycle the request is first presented and high on the next cycle. With the default this is 7 low cycles, high on cycle 8.
- Inputs are sampled only in IDLE. Changes to inputs during LO/HI are ignored.
- read_data changes only on read captures and on reset. It holds across writes and idle cycles.
- WE_N/OE_N are never both low. DQ is driven only during write LO/HI.
- rst asserted mid-access: immediate return to IDLE, strobes deassert and the bus floats. A partially written word is not completed.
- Back-to-back requests: the DONE->IDLE cycle presents the next request (the upstream register advanced on the DONE edge). The new access starts with no extra bubble beyond the IDLE cycle.

Optional Feature:
- Macro MEM_ADDR_CHECK_EN.
- Defined: adds output addr_err (1 bit, reset 0). In IDLE, a request with address<BASE_ADDR or address[1:0]!=0 goes directly to DONE:
  - No SRAM strobes are issued and read_data is unchanged.
  - addr_err=1 during that DONE cycle only; ready is low for 1 cycle.
- Undefined: no addr_err port. All addresses take the normal path with wrapped offset and ignored low bits.

Test Plan:
- Store 0xDEADBEEF at address 1024, default params -> SRAM half-word 0 = 0xBEEF, half-word 1 = 0xDEAD; ready low exactly 7 cycles, WE_N low 6 cycles.
- Load from 1024 after the above -> read_data = 0xDEADBEEF in the DONE cycle and held afterward. OE_N is low 6 cycles and DQ is never driven by the block.
- Store 0x12345678 at 1032, then load 1032 and load 1024 back-to-back -> SRAM addr 4/5 = 0x5678/0x1234; reads return 0x12345678 then 0xDEADBEEF; ready pattern is 7 low / 1 high per access.
- rd_en=wr_en=1, address 1028, data 0xA5A5_5A5A -> write is performed (SRAM 2/3 = 0x5A5A/0xA5A5) and read_data is unchanged.
- Assert rst during HI of a store -> strobes are high and DQ is Z in the same cycle; read_data=0, ready=1. The next store completes normally.
- MEM_ADDR_CHECK_EN: load from 1000 and store to 1026 -> each gives addr_err=1 for one cycle, ready low 1 cycle, and no SRAM strobe activity.
